// File: rtl/victim_tag_array.sv
// Fully-associative victim-cache tag array: registered lookup, allocation with
// free-way / round-robin replacement, eviction reporting, occupancy and flush.
module victim_tag_array #(
   parameter int TAG_WIDTH = 4,
   parameter int NUM_WAYS  = 4,
   parameter int WAY_W     = $clog2(NUM_WAYS),
   parameter int CNT_W     = $clog2(NUM_WAYS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 lookup_en,
   input  logic [TAG_WIDTH-1:0] lookup_tag,
   input  logic                 lookup_inv,
   output logic                 lookup_valid,
   output logic                 lookup_hit,
   output logic [WAY_W-1:0]     lookup_way,
   output logic                 lookup_dirty,
   input  logic                 alloc_en,
   input  logic [TAG_WIDTH-1:0] alloc_tag,
   input  logic                 alloc_dirty,
   output logic                 alloc_done,
   output logic [WAY_W-1:0]     alloc_way,
   output logic                 evict_valid,
   output logic [TAG_WIDTH-1:0] evict_tag,
   output logic                 evict_dirty,
   input  logic                 dirty_set,
   input  logic [WAY_W-1:0]     dirty_way,
   input  logic                 flush,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 full,
   output logic                 empty
);

   logic [TAG_WIDTH-1:0] tag_q [NUM_WAYS];
   logic [NUM_WAYS-1:0]  valid_q;
   logic [NUM_WAYS-1:0]  dirty_q;
   logic [WAY_W-1:0]     rr_ptr;

   logic                 lk_hit;
   logic [WAY_W-1:0]     lk_way;
   logic                 lk_dirty;
   logic                 dup;
   logic [WAY_W-1:0]     dup_way;
   logic                 free;
   logic [WAY_W-1:0]     free_way;
   logic [WAY_W-1:0]     al_way;
   logic                 al_evict;
   logic [TAG_WIDTH-1:0] old_tag;
   logic                 old_dirty;
   logic                 al_act;
   logic                 lk_act;
   logic                 inv_act;
   logic                 occ_inc;
   logic                 occ_dec;
   logic [CNT_W-1:0]     occ_next;

   // Associative searches run descending so the lowest matching index wins.
   always_comb begin
      lk_hit   = 1'b0;
      lk_way   = '0;
      lk_dirty = 1'b0;
      dup      = 1'b0;
      dup_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_q[i] == lookup_tag) begin
            lk_hit   = 1'b1;
            lk_way   = WAY_W'(i);
            lk_dirty = dirty_q[i];
         end
         if (valid_q[i] && tag_q[i] == alloc_tag) begin
            dup     = 1'b1;
            dup_way = WAY_W'(i);
         end
         if (!valid_q[i]) begin
            free     = 1'b1;
            free_way = WAY_W'(i);
         end
      end
   end

   always_comb begin
      al_way    = dup ? dup_way : (free ? free_way : rr_ptr);
      al_evict  = !dup && !free;
      old_tag   = '0;
      old_dirty = 1'b0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (al_way == WAY_W'(i)) begin
            old_tag   = tag_q[i];
            old_dirty = dirty_q[i];
         end
      end
      al_act   = alloc_en && !flush;
      lk_act   = lookup_en && !flush;
      inv_act  = lk_act && lookup_inv && lk_hit;
      // An invalidate overwritten by a same-way allocation leaves the way valid.
      occ_inc  = al_act && !dup && free;
      occ_dec  = inv_act && !(al_act && al_way == lk_way);
      occ_next = occupancy + CNT_W'(occ_inc) - CNT_W'(occ_dec);
   end

   // Per-way storage update: flush > alloc > invalidate > dirty_set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
         rr_ptr  <= '0;
         for (int i = 0; i < NUM_WAYS; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (flush) begin
            rr_ptr <= '0;
         end else if (al_act && al_evict) begin
            rr_ptr <= (rr_ptr == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_ptr + 1'b1;
         end
         for (int i = 0; i < NUM_WAYS; i++) begin
            if (flush) begin
               valid_q[i] <= 1'b0;
               dirty_q[i] <= 1'b0;
            end else if (al_act && al_way == WAY_W'(i)) begin
               valid_q[i] <= 1'b1;
               tag_q[i]   <= alloc_tag;
               dirty_q[i] <= alloc_dirty | (dup & dirty_q[i]);
            end else if (inv_act && lk_way == WAY_W'(i)) begin
               valid_q[i] <= 1'b0;
               dirty_q[i] <= 1'b0;
            end else if (dirty_set && dirty_way == WAY_W'(i) && valid_q[i]) begin
               dirty_q[i] <= 1'b1;
            end
         end
      end
   end

   // Result registers: pulses every cycle, data fields only when pulsed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lookup_valid <= 1'b0;
         lookup_hit   <= 1'b0;
         lookup_way   <= '0;
         lookup_dirty <= 1'b0;
         alloc_done   <= 1'b0;
         alloc_way    <= '0;
         evict_valid  <= 1'b0;
         evict_tag    <= '0;
         evict_dirty  <= 1'b0;
         occupancy    <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
      end else begin
         lookup_valid <= lk_act;
         alloc_done   <= al_act;
         if (lk_act) begin
            lookup_hit   <= lk_hit;
            lookup_way   <= lk_way;
            lookup_dirty <= lk_dirty;
         end
         if (al_act) begin
            alloc_way   <= al_way;
            evict_valid <= al_evict;
            if (al_evict) begin
               evict_tag   <= old_tag;
               evict_dirty <= old_dirty;
            end
         end
         occupancy <= flush ? '0 : occ_next;
         full      <= !flush && (occ_next == CNT_W'(NUM_WAYS));
         empty     <= flush || (occ_next == '0);
      end
   end

endmodule

// File: tb/tb_victim_tag_array.sv
// Scoreboard bench for victim_tag_array: expected results are queued when
// stimulus is driven and checked by a monitor when the pulses appear.
module tb_victim_tag_array;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lookup_en;
   logic [3:0] lookup_tag;
   logic       lookup_inv;
   logic       lookup_valid;
   logic       lookup_hit;
   logic [1:0] lookup_way;
   logic       lookup_dirty;
   logic       alloc_en;
   logic [3:0] alloc_tag;
   logic       alloc_dirty;
   logic       alloc_done;
   logic [1:0] alloc_way;
   logic       evict_valid;
   logic [3:0] evict_tag;
   logic       evict_dirty;
   logic       dirty_set;
   logic [1:0] dirty_way;
   logic       flush;
   logic [2:0] occupancy;
   logic       full;
   logic       empty;

   typedef struct packed {
      logic       hit;
      logic [1:0] way;
      logic       dirty;
   } lk_exp_t;

   typedef struct packed {
      logic [1:0] way;
      logic       ev;
      logic [3:0] tag;
      logic       evd;
   } al_exp_t;

   lk_exp_t lk_q [$];
   al_exp_t al_q [$];
   int      total = 0;
   int      bad   = 0;

   victim_tag_array #(.TAG_WIDTH(4), .NUM_WAYS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .lookup_en(lookup_en), .lookup_tag(lookup_tag), .lookup_inv(lookup_inv),
      .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
      .lookup_way(lookup_way), .lookup_dirty(lookup_dirty),
      .alloc_en(alloc_en), .alloc_tag(alloc_tag), .alloc_dirty(alloc_dirty),
      .alloc_done(alloc_done), .alloc_way(alloc_way),
      .evict_valid(evict_valid), .evict_tag(evict_tag), .evict_dirty(evict_dirty),
      .dirty_set(dirty_set), .dirty_way(dirty_way), .flush(flush),
      .occupancy(occupancy), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (lookup_valid === 1'b1) begin
         total++;
         if (lk_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL lookup_unexpected: lookup_valid=1 with nothing expected");
         end else begin
            lk_exp_t e;
            e = lk_q.pop_front();
            if ({lookup_hit, lookup_way, lookup_dirty} !== e) begin
               bad++;
               $display("[TB] FAIL lookup_result: got hit=%b way=%0d dirty=%b want hit=%b way=%0d dirty=%b",
                        lookup_hit, lookup_way, lookup_dirty, e.hit, e.way, e.dirty);
            end
         end
      end
      if (alloc_done === 1'b1) begin
         total++;
         if (al_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL alloc_unexpected: alloc_done=1 with nothing expected");
         end else begin
            al_exp_t e;
            al_exp_t got;
            e   = al_q.pop_front();
            got = {alloc_way, evict_valid, e.ev ? evict_tag : 4'h0, e.ev ? evict_dirty : 1'b0};
            if (got !== e) begin
               bad++;
               $display("[TB] FAIL alloc_result: got way=%0d ev=%b tag=%h evd=%b want way=%0d ev=%b tag=%h evd=%b",
                        got.way, got.ev, got.tag, got.evd, e.way, e.ev, e.tag, e.evd);
            end
         end
      end
   end

   task automatic idle();
      lookup_en   = 1'b0;
      lookup_tag  = '0;
      lookup_inv  = 1'b0;
      alloc_en    = 1'b0;
      alloc_tag   = '0;
      alloc_dirty = 1'b0;
      dirty_set   = 1'b0;
      dirty_way   = '0;
      flush       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic applyStimulus_alloc(input logic [3:0] tag, input logic d,
                                      input logic [1:0] ew, input logic ev,
                                      input logic [3:0] et, input logic ed);
      alloc_en    = 1'b1;
      alloc_tag   = tag;
      alloc_dirty = d;
      al_q.push_back('{way: ew, ev: ev, tag: et, evd: ed});
   endtask

   task automatic applyStimulus_lookup(input logic [3:0] tag, input logic inv,
                                       input logic eh, input logic [1:0] ew,
                                       input logic ed);
      lookup_en  = 1'b1;
      lookup_tag = tag;
      lookup_inv = inv;
      lk_q.push_back('{hit: eh, way: ew, dirty: ed});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      total++;
      if ({lookup_valid, lookup_hit, lookup_way, lookup_dirty} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_lookup_outs: got %b want 00000",
                  {lookup_valid, lookup_hit, lookup_way, lookup_dirty});
      end
      total++;
      if ({alloc_done, alloc_way, evict_valid, evict_tag, evict_dirty} !== 9'b0) begin
         bad++;
         $display("[TB] FAIL reset_alloc_outs: got %b want 0",
                  {alloc_done, alloc_way, evict_valid, evict_tag, evict_dirty});
      end
      total++;
      if ({occupancy, full, empty} !== 5'b00001) begin
         bad++;
         $display("[TB] FAIL reset_occ: got occ=%0d full=%b empty=%b want 0 0 1", occupancy, full, empty);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      applyStimulus_alloc(4'h1, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
      tick();
      applyStimulus_alloc(4'h2, 1'b0, 2'd1, 1'b0, 4'h0, 1'b0);
      tick();
      applyStimulus_alloc(4'h3, 1'b0, 2'd2, 1'b0, 4'h0, 1'b0);
      tick();
      total++;
      if ({occupancy, full, empty} !== {3'd3, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL fill_occ: got occ=%0d full=%b empty=%b want 3 0 0", occupancy, full, empty);
      end
      applyStimulus_lookup(4'h2, 1'b0, 1'b1, 2'd1, 1'b0);
      tick();
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL fill_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_replace();
      applyStimulus_alloc(4'h4, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0);
      tick();
      total++;
      if ({occupancy, full, empty} !== {3'd4, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL replace_full: got occ=%0d full=%b empty=%b want 4 1 0", occupancy, full, empty);
      end
      dirty_set = 1'b1;
      dirty_way = 2'd0;
      tick();
      applyStimulus_alloc(4'h5, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1);
      tick();
      applyStimulus_alloc(4'h6, 1'b0, 2'd1, 1'b1, 4'h2, 1'b0);
      tick();
      total++;
      if (occupancy !== 3'd4) begin
         bad++;
         $display("[TB] FAIL replace_occ: got %0d want 4", occupancy);
      end
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL replace_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_invalidate();
      applyStimulus_lookup(4'h3, 1'b1, 1'b1, 2'd2, 1'b0);
      tick();
      total++;
      if ({occupancy, full} !== {3'd3, 1'b0}) begin
         bad++;
         $display("[TB] FAIL inv_occ: got occ=%0d full=%b want 3 0", occupancy, full);
      end
      applyStimulus_alloc(4'h7, 1'b0, 2'd2, 1'b0, 4'h0, 1'b0);
      tick();
      total++;
      if (occupancy !== 3'd4) begin
         bad++;
         $display("[TB] FAIL inv_refill_occ: got %0d want 4", occupancy);
      end
      applyStimulus_lookup(4'h2, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      applyStimulus_lookup(4'h6, 1'b0, 1'b1, 2'd1, 1'b0);
      tick();
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL inv_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_wrap();
      applyStimulus_alloc(4'h8, 1'b0, 2'd2, 1'b1, 4'h7, 1'b0);
      tick();
      applyStimulus_alloc(4'hA, 1'b0, 2'd3, 1'b1, 4'h4, 1'b0);
      tick();
      applyStimulus_alloc(4'hB, 1'b0, 2'd0, 1'b1, 4'h5, 1'b0);
      tick();
      total++;
      if ({occupancy, full} !== {3'd4, 1'b1}) begin
         bad++;
         $display("[TB] FAIL wrap_occ: got occ=%0d full=%b want 4 1", occupancy, full);
      end
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL wrap_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_same_cycle();
      applyStimulus_lookup(4'hB, 1'b1, 1'b1, 2'd0, 1'b0);
      tick();
      total++;
      if (occupancy !== 3'd3) begin
         bad++;
         $display("[TB] FAIL same_inv_occ: got %0d want 3", occupancy);
      end
      applyStimulus_alloc(4'h9, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
      applyStimulus_lookup(4'h9, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      applyStimulus_lookup(4'h9, 1'b0, 1'b1, 2'd0, 1'b0);
      tick();
      applyStimulus_alloc(4'h6, 1'b1, 2'd1, 1'b0, 4'h0, 1'b0);
      tick();
      total++;
      if (occupancy !== 3'd4) begin
         bad++;
         $display("[TB] FAIL dup_occ: got %0d want 4", occupancy);
      end
      applyStimulus_lookup(4'h6, 1'b0, 1'b1, 2'd1, 1'b1);
      tick();
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL same_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus_lookup(4'h6, 1'b1, 1'b1, 2'd1, 1'b1);
      applyStimulus_alloc(4'hC, 1'b0, 2'd1, 1'b1, 4'h6, 1'b1);
      tick();
      total++;
      if ({occupancy, full} !== {3'd4, 1'b1}) begin
         bad++;
         $display("[TB] FAIL b2b_occ: got occ=%0d full=%b want 4 1", occupancy, full);
      end
      applyStimulus_lookup(4'h6, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      applyStimulus_lookup(4'hC, 1'b0, 1'b1, 2'd1, 1'b0);
      applyStimulus_alloc(4'hD, 1'b0, 2'd2, 1'b1, 4'h8, 1'b0);
      tick();
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL b2b_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_flush();
      flush      = 1'b1;
      alloc_en   = 1'b1;
      alloc_tag  = 4'hE;
      lookup_en  = 1'b1;
      lookup_tag = 4'h9;
      tick();
      total++;
      if ({alloc_done, lookup_valid, occupancy, full, empty} !== {1'b0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL flush_state: got done=%b lv=%b occ=%0d full=%b empty=%b want 0 0 0 0 1",
                  alloc_done, lookup_valid, occupancy, full, empty);
      end
      applyStimulus_lookup(4'h9, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      applyStimulus_lookup(4'hC, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      applyStimulus_lookup(4'hD, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      applyStimulus_lookup(4'hA, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      dirty_set = 1'b1;
      dirty_way = 2'd0;
      tick();
      applyStimulus_alloc(4'h1, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0);
      tick();
      total++;
      if ({occupancy, empty} !== {3'd1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL flush_refill: got occ=%0d empty=%b want 1 0", occupancy, empty);
      end
      applyStimulus_lookup(4'h1, 1'b0, 1'b1, 2'd0, 1'b0);
      tick();
      tick();
      total++;
      if (lk_q.size() != 0 || al_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL flush_pending: got %0d/%0d pending want 0/0", lk_q.size(), al_q.size());
      end
   endtask

   task automatic test_reset_mid();
      alloc_en  = 1'b1;
      alloc_tag = 4'h2;
      rst_n     = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if ({alloc_done, lookup_valid, alloc_way, evict_valid, lookup_hit} !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_mid_outs: got %b want 000000",
                  {alloc_done, lookup_valid, alloc_way, evict_valid, lookup_hit});
      end
      total++;
      if ({occupancy, full, empty} !== 5'b00001) begin
         bad++;
         $display("[TB] FAIL reset_mid_occ: got occ=%0d full=%b empty=%b want 0 0 1", occupancy, full, empty);
      end
      tick();
      total++;
      if (alloc_done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_mid_pulse: got alloc_done=%b want 0", alloc_done);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_replace();
      test_invalidate();
      test_wrap();
      test_same_cycle();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
